// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared types for the fetch front end.
//   IF_ID_PACKET - packet handed to decode (inst, PC, NPC, valid)
//   FETCH_ENTRY  - one buffered instruction (inst, PC, NPC)
//   XLEN, FQ_DEPTH_DEF - datapath width and default queue depth
package fetch_queue_pkg;
  localparam int XLEN         = 32;
  localparam int FQ_DEPTH_DEF = 4;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] NPC;
    logic            valid;
  } IF_ID_PACKET;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] NPC;
  } FETCH_ENTRY;
endpackage

// File: rtl/fq_fifo.sv
// fq_fifo: circular buffer of FETCH_ENTRY accepting 0-2 pushes and 0-1 pop
// per cycle.
//   clock, reset     - clock, synchronous active-high reset
//   flush            - empty the buffer next cycle
//   push0/entry0     - first push, written at tail
//   push1/entry1     - second push, written at tail+1 (only with push0)
//   pop              - retire head
//   head             - current head entry (valid only when count != 0)
//   count            - occupancy, one bit wider than the pointers
module fq_fifo
  import fetch_queue_pkg::*;
#(
  parameter int  DEPTH = FQ_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       push0,
  input  logic       push1,
  input  FETCH_ENTRY entry0,
  input  FETCH_ENTRY entry1,
  input  logic       pop,
  output FETCH_ENTRY head,
  output logic [AW:0] count
);
  FETCH_ENTRY      mem [DEPTH];
  logic [AW-1:0]   hd, tl, tl1;

  assign tl1  = tl + AW'(1);
  assign head = mem[hd];

  // Per-slot write port: a slot takes entry0 when it is the tail, entry1
  // when it is the slot after the tail.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    always_ff @(posedge clock) begin
      if (push0 && tl == AW'(i))
        mem[i] <= entry0;
      else if (push1 && tl1 == AW'(i))
        mem[i] <= entry1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
    end else begin
      tl    <= tl + AW'(push0) + AW'(push1);
      if (pop) hd <= hd + AW'(1);
      count <= count + (AW+1)'(push0) + (AW+1)'(push1) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, issues aligned 64-bit line requests (one in
// flight at most), splits responses into 32-bit instructions, and presents
// them to decode through a small FIFO. Handles squash/redirect including a
// stale in-flight response.
//   clock, reset            - clock, synchronous active-high reset
//   squash_en, squash_pc    - redirect; flushes queue, reloads PC
//   stop_fetch              - inhibit new requests (queue still drains)
//   imem_req_valid/addr/ready - line request handshake
//   imem_rsp_valid/data     - line response (low word at addr)
//   if_packet, id_ready     - FIFO head to decode, consumed when ready
//   fq_count                - queue occupancy
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              FQ_DEPTH = FQ_DEPTH_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int             CW       = $clog2(FQ_DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            squash_en,
  input  logic [XLEN-1:0] squash_pc,
  input  logic            stop_fetch,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [63:0]     imem_rsp_data,
  output IF_ID_PACKET     if_packet,
  input  logic            id_ready,
  output logic [CW-1:0]   fq_count
);
  logic [XLEN-1:0] pc;
  logic            outstanding, drop_next;
  logic            rsp_fire, push0, push1, pop, room;
  FETCH_ENTRY      entry0, entry1, head;

  // Two free slots before issuing, so any response always fits.
  assign room           = fq_count <= CW'(FQ_DEPTH - 2);
  assign imem_req_valid = !reset && !outstanding && !stop_fetch && !squash_en && room;
  assign imem_req_addr  = {pc[XLEN-1:3], 3'b000};

  assign rsp_fire = imem_rsp_valid && outstanding;
  assign push0    = rsp_fire && !drop_next && !squash_en;
  // Second word only when fetch starts on the low half of the line.
  assign push1    = push0 && !pc[2];

  assign entry0 = '{inst: pc[2] ? imem_rsp_data[63:32] : imem_rsp_data[31:0],
                    PC: pc, NPC: pc + 32'd4};
  assign entry1 = '{inst: imem_rsp_data[63:32], PC: pc + 32'd4, NPC: pc + 32'd8};

  assign if_packet = '{inst: head.inst, PC: head.PC, NPC: head.NPC,
                       valid: (fq_count != '0) && !squash_en};
  assign pop       = if_packet.valid && id_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      outstanding <= 1'b0;
      drop_next   <= 1'b0;
    end else if (squash_en) begin
      pc <= squash_pc;
      if (rsp_fire) begin
        // Response landed in the squash cycle itself: consume and discard.
        outstanding <= 1'b0;
        drop_next   <= 1'b0;
      end else if (outstanding) begin
        drop_next   <= 1'b1;
      end
    end else if (rsp_fire) begin
      outstanding <= 1'b0;
      if (drop_next) drop_next <= 1'b0;
      else           pc <= pc + (pc[2] ? 32'd4 : 32'd8);
    end else if (imem_req_valid && imem_req_ready) begin
      outstanding <= 1'b1;
    end
  end

  fq_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (squash_en),
    .push0 (push0),
    .push1 (push1),
    .entry0(entry0),
    .entry1(entry1),
    .pop   (pop),
    .head  (head),
    .count (fq_count)
  );
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic            clock = 1'b0;
  logic            reset, squash_en, stop_fetch, imem_req_ready, imem_rsp_valid, id_ready;
  logic [31:0]     squash_pc;
  logic [63:0]     imem_rsp_data;
  logic            imem_req_valid;
  logic [31:0]     imem_req_addr;
  IF_ID_PACKET     if_packet;
  logic [2:0]      fq_count;

  fetch_queue #(.FQ_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .squash_en(squash_en), .squash_pc(squash_pc),
    .stop_fetch(stop_fetch), .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_packet(if_packet), .id_ready(id_ready), .fq_count(fq_count)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] inst, pc, npc; } exp_t;
  exp_t sb[$];

  int n_assert = 0, n_fail = 0;
  int n_pkts = 0, gaps = 0, viol = 0, max_cnt = 0;
  logic mem_auto = 1'b1, mon_en = 1'b0, gap_en = 1'b0, bp_en = 1'b0, seen = 1'b0;
  logic [31:0] exp_pc = 32'h0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, 16'h0013};
  endfunction

  function automatic logic [63:0] line_of(input logic [31:0] a);
    return {inst_of(a + 32'd4), inst_of(a)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: sample at negedge (decode monitor + memory model), then
  // drive at posedge+1.
  task automatic step();
    logic        acc;
    logic [31:0] acc_addr;
    exp_t        e;
    @(negedge clock);
    if (mon_en && if_packet.valid && id_ready) begin
      n_pkts++;
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("pkt_inst", if_packet.inst, e.inst);
        chk("pkt_pc",   if_packet.PC,   e.pc);
        chk("pkt_npc",  if_packet.NPC,  e.npc);
      end
    end
    if (gap_en) begin
      if (if_packet.valid) seen = 1'b1;
      else if (seen)       gaps++;
    end
    if (bp_en) begin
      if (int'(fq_count) > max_cnt) max_cnt = int'(fq_count);
      if (int'(fq_count) > DEPTH - 2 && imem_req_valid) viol++;
    end
    acc      = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    @(posedge clock);
    #1;
    if (mem_auto) begin
      imem_rsp_valid = acc;
      if (acc) begin
        imem_rsp_data = line_of(acc_addr);
        chk("req_addr", acc_addr, {exp_pc[31:3], 3'b000});
        if (!exp_pc[2]) begin
          sb.push_back('{inst_of(acc_addr), exp_pc, exp_pc + 32'd4});
          sb.push_back('{inst_of(acc_addr + 32'd4), exp_pc + 32'd4, exp_pc + 32'd8});
          exp_pc = exp_pc + 32'd8;
        end else begin
          sb.push_back('{inst_of(acc_addr + 32'd4), exp_pc, exp_pc + 32'd4});
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; squash_en = 1'b0; squash_pc = '0; stop_fetch = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; id_ready = 1'b0;
    steps(2);
    chk("rst_count", 32'(fq_count), 32'd0);
    chk("rst_valid", 32'(if_packet.valid), 32'd0);
    chk("rst_req",   32'(imem_req_valid), 32'd0);

    // Streaming run from RESET_PC
    exp_pc = 32'h0; mon_en = 1'b1; gap_en = 1'b1; id_ready = 1'b1; imem_req_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr",  imem_req_addr, 32'h0);
    steps(40);
    chk("stream_gaps", gaps, 0);
    chk("stream_pkts_ge30", 32'(n_pkts >= 30), 32'd1);
    gap_en = 1'b0; stop_fetch = 1'b1;
    steps(10);
    chk("stream_sb_empty", sb.size(), 0);
    chk("stream_drained",  32'(fq_count), 32'd0);

    // Unaligned start
    mem_auto = 1'b0; mon_en = 1'b0; imem_req_ready = 1'b0; id_ready = 1'b0;
    squash_en = 1'b1; squash_pc = 32'h104; stop_fetch = 1'b0;
    step();
    squash_en = 1'b0;
    #1;
    chk("ua_req_valid", 32'(imem_req_valid), 32'd1);
    chk("ua_req_addr",  imem_req_addr, 32'h100);
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 64'hAAAA0013_BBBB0013;
    step();
    imem_rsp_valid = 1'b0;
    chk("ua_count", 32'(fq_count), 32'd1);
    chk("ua_pc",    if_packet.PC, 32'h104);
    chk("ua_inst",  if_packet.inst, 32'hAAAA0013);
    chk("ua_npc",   if_packet.NPC, 32'h108);
    chk("ua_next_addr", imem_req_addr, 32'h108);
    id_ready = 1'b1; step(); id_ready = 1'b0;
    chk("ua_popped", 32'(fq_count), 32'd0);

    // Backpressure
    exp_pc = 32'h108; mem_auto = 1'b1; mon_en = 1'b1; bp_en = 1'b1; imem_req_ready = 1'b1;
    steps(20);
    chk("bp_max_count", max_cnt, DEPTH);
    chk("bp_no_req_when_full", viol, 0);
    chk("bp_count_sat", 32'(fq_count), 32'd4);
    chk("bp_sb_size", sb.size(), 4);
    id_ready = 1'b1;
    steps(20);
    stop_fetch = 1'b1;
    steps(10);
    bp_en = 1'b0;
    chk("bp_no_loss", sb.size(), 0);
    chk("bp_drained", 32'(fq_count), 32'd0);
    chk("bp_viol_after", viol, 0);

    // Squash with outstanding request; back-to-back squash, last wins
    mem_auto = 1'b0; mon_en = 1'b0; imem_req_ready = 1'b0; id_ready = 1'b0;
    squash_en = 1'b1; squash_pc = 32'h40; stop_fetch = 1'b0;
    step();
    squash_en = 1'b0;
    #1;
    chk("sq_req_addr40", imem_req_addr, 32'h40);
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    squash_en = 1'b1; squash_pc = 32'h300; step();
    squash_pc = 32'h200; step();
    squash_en = 1'b0;
    #1;
    chk("sq_wait_stale", 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = line_of(32'h40);
    step();
    imem_rsp_valid = 1'b0;
    chk("sq_stale_dropped", 32'(fq_count), 32'd0);
    chk("sq_req_valid", 32'(imem_req_valid), 32'd1);
    chk("sq_req_addr200", imem_req_addr, 32'h200);
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = line_of(32'h200);
    step();
    imem_rsp_valid = 1'b0;
    chk("sq_count", 32'(fq_count), 32'd2);
    chk("sq_pc",    if_packet.PC, 32'h200);
    chk("sq_inst",  if_packet.inst, inst_of(32'h200));

    // Squash coincident with a response and id_ready
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    squash_en = 1'b1; squash_pc = 32'h400; id_ready = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = line_of(32'h208);
    #1;
    chk("co_valid_low", 32'(if_packet.valid), 32'd0);
    step();
    squash_en = 1'b0; id_ready = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    chk("co_count", 32'(fq_count), 32'd0);
    chk("co_req_valid", 32'(imem_req_valid), 32'd1);
    chk("co_req_addr", imem_req_addr, 32'h400);
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = line_of(32'h400);
    step();
    imem_rsp_valid = 1'b0;
    chk("co_count2", 32'(fq_count), 32'd2);
    chk("co_pc", if_packet.PC, 32'h400);
    chk("co_inst", if_packet.inst, inst_of(32'h400));

    // Reset while a request is outstanding, then a late response
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    reset = 1'b1;
    step();
    chk("mr_count", 32'(fq_count), 32'd0);
    chk("mr_valid", 32'(if_packet.valid), 32'd0);
    chk("mr_req",   32'(imem_req_valid), 32'd0);
    reset = 1'b0;
    #1;
    chk("mr_req_resume", 32'(imem_req_valid), 32'd1);
    chk("mr_req_addr",   imem_req_addr, 32'h0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 64'hDEADBEEF_DEADBEEF;
    step();
    imem_rsp_valid = 1'b0;
    chk("mr_late_ignored", 32'(fq_count), 32'd0);
    chk("mr_not_outstanding", 32'(imem_req_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
